frame_serializer: RTL and testbench

//  Transmit-side framer for the DCT UART link: takes one 256-bit result word per

---
 rtl/frame_serializer_pkg.sv | 16 +
 rtl/frame_serializer.sv | 146 ++++++++++++++
 tb/tb_frame_serializer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_serializer_pkg.sv
// Shared framing constants for the DCT UART link, used by the TX framer
// and the RX deframer.
package frame_serializer_pkg;

    localparam int unsigned FRAME_NBYTES = 32;
    localparam logic [7:0]  FRAME_HDR    = 8'hA5;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 3'd0;
    localparam fsm_state_t ST_HDR  = 3'd1;
    localparam fsm_state_t ST_PAY  = 3'd2;
    localparam fsm_state_t ST_CSUM = 3'd3;
    localparam fsm_state_t ST_GAP  = 3'd4;

endpackage

// File: rtl/frame_serializer.sv
// Transmit-side framer: one result word per strobe in, a UART byte stream out
// (optional header, payload MSB byte first, optional XOR trailer).
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int unsigned NBYTES      = FRAME_NBYTES,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  HEADER_BYTE = FRAME_HDR,
    parameter bit          CSUM_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*NBYTES-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_busy,
    output logic                frame_active,
    output logic                frame_done,
    output logic                overflow,
    output logic [15:0]         frames_sent
);

    localparam int unsigned     W        = 8 * NBYTES;
    localparam int unsigned     IDXW     = $clog2(NBYTES + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES);
    localparam fsm_state_t      FIRST_ST = HEADER_EN ? ST_HDR : ST_PAY;

    fsm_state_t      state_q, state_d;
    fsm_state_t      prev_q, prev_d;
    logic [W-1:0]    pend_q, pend_d;
    logic            pendFull_q, pendFull_d;
    logic [W-1:0]    active_q, active_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      txByte_q, txByte_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     frames_q, frames_d;
    logic            issue;
    logic            frameEnd;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        pend_d     = pend_q;
        pendFull_d = pendFull_q;
        active_d   = active_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        txByte_d   = txByte_q;
        overflow_d = overflow_q;
        frames_d   = frames_q;
        issue      = 1'b0;
        frameEnd   = 1'b0;

        if (in_valid && !pendFull_q) begin
            pend_d     = in_data;
            pendFull_d = 1'b1;
        end
        if (in_valid && pendFull_q) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pendFull_q) begin
                    active_d   = pend_q;
                    pendFull_d = 1'b0;
                    idx_d      = '0;
                    csum_d     = 8'h00;
                    state_d    = FIRST_ST;
                end
            end
            ST_HDR, ST_PAY, ST_CSUM: begin
                if (!tx_busy) begin
                    issue   = 1'b1;
                    prev_d  = state_q;
                    state_d = ST_GAP;
                    if (state_q == ST_HDR) begin
                        txByte_d = HEADER_BYTE;
                    end else if (state_q == ST_CSUM) begin
                        txByte_d = csum_q;
                    end else begin
                        txByte_d = active_q[W-1 -: 8];
                        active_d = active_q << 8;
                        csum_d   = csum_q ^ active_q[W-1 -: 8];
                        idx_d    = idx_q + 1'b1;
                    end
                end
            end
            // The holdoff cycle gives uart_tx time to raise busy before the
            // next byte is considered.
            ST_GAP: begin
                if (prev_q == ST_HDR) begin
                    state_d = ST_PAY;
                end else if (prev_q == ST_PAY && idx_q != LAST_IDX) begin
                    state_d = ST_PAY;
                end else if (prev_q == ST_PAY && CSUM_EN) begin
                    state_d = ST_CSUM;
                end else begin
                    frameEnd = 1'b1;
                    state_d  = ST_IDLE;
                    frames_d = frames_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prev_q     <= ST_IDLE;
            pend_q     <= '0;
            pendFull_q <= 1'b0;
            active_q   <= '0;
            idx_q      <= '0;
            csum_q     <= 8'h00;
            txByte_q   <= 8'h00;
            overflow_q <= 1'b0;
            frames_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            pendFull_q <= pendFull_d;
            active_q   <= active_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            txByte_q   <= txByte_d;
            overflow_q <= overflow_d;
            frames_q   <= frames_d;
        end
    end

    // Strobes are suppressed during reset so an abandoned frame cannot leak a byte.
    assign tx_valid     = issue && !reset;
    assign frame_done   = frameEnd && !reset;
    assign tx_byte      = txByte_d;
    assign in_ready     = !pendFull_q;
    assign frame_active = (state_q != ST_IDLE);
    assign overflow     = overflow_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: three configurations driven against a uart_tx
// busy model, with byte streams checked against a frame-level reference model.
module tb_frame_serializer;

    localparam int MEM = 1024;

    logic             clk;
    logic             reset;
    logic [255:0]     inData0, inData1;
    logic [23:0]      inData2;
    logic [2:0]       inValid;
    logic [2:0]       inReady;
    logic [2:0][7:0]  txByte;
    logic [2:0]       txValid;
    logic [2:0]       txBusy;
    logic [2:0]       frameActive;
    logic [2:0]       frameDone;
    logic [2:0]       overflow;
    logic [2:0][15:0] framesSent;

    int        busyCnt [3];
    bit  [2:0] issued;
    bit  [2:0] forceBusy;
    logic [7:0] capMem [3][MEM];
    logic [7:0] expMem [3][MEM];
    int capCnt [3];
    int capPtr [3];
    int expCnt [3];
    int expPtr [3];
    int doneCnt [3];
    int doneBase [3];
    int violations [3];
    int compared;
    int mismatched;

    frame_serializer #(.NBYTES(32), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5), .CSUM_EN(1'b1)) dutA (
        .clk(clk), .reset(reset), .in_data(inData0), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .tx_byte(txByte[0]), .tx_valid(txValid[0]), .tx_busy(txBusy[0]), .frame_active(frameActive[0]),
        .frame_done(frameDone[0]), .overflow(overflow[0]), .frames_sent(framesSent[0]));

    frame_serializer #(.NBYTES(32), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5), .CSUM_EN(1'b1)) dutB (
        .clk(clk), .reset(reset), .in_data(inData1), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .tx_byte(txByte[1]), .tx_valid(txValid[1]), .tx_busy(txBusy[1]), .frame_active(frameActive[1]),
        .frame_done(frameDone[1]), .overflow(overflow[1]), .frames_sent(framesSent[1]));

    frame_serializer #(.NBYTES(3), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5), .CSUM_EN(1'b1)) dutC (
        .clk(clk), .reset(reset), .in_data(inData2), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .tx_byte(txByte[2]), .tx_valid(txValid[2]), .tx_busy(txBusy[2]), .frame_active(frameActive[2]),
        .frame_done(frameDone[2]), .overflow(overflow[2]), .frames_sent(framesSent[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign txBusy[0] = (busyCnt[0] != 0) || forceBusy[0];
    assign txBusy[1] = (busyCnt[1] != 0) || forceBusy[1];
    assign txBusy[2] = (busyCnt[2] != 0) || forceBusy[2];

    // uart_tx stand-in: busy rises the cycle after an issue and stays up 10-13 cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (issued[i]) busyCnt[i] <= 10 + int'($urandom_range(0, 3));
            else if (busyCnt[i] > 0) busyCnt[i] <= busyCnt[i] - 1;
        end
    end

    // Mid-cycle monitor: records every issued byte, frame_done pulses and issues while busy.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            issued[i] = txValid[i];
            if (txValid[i]) begin
                capMem[i][capCnt[i] % MEM] = txByte[i];
                capCnt[i] = capCnt[i] + 1;
                if (txBusy[i]) violations[i] = violations[i] + 1;
            end
            if (frameDone[i]) doneCnt[i] = doneCnt[i] + 1;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [255:0] word);
        if (i == 0) inData0 = word;
        else if (i == 1) inData1 = word;
        else inData2 = word[23:0];
        inValid[i] = 1'b1;
        tick();
        inValid[i] = 1'b0;
    endtask

    // Reference frame: optional A5, payload bytes MSB first, XOR of payload bytes.
    task automatic pushFrame(input int i, input logic [255:0] word, input int nb, input bit hdr, input bit cs);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        if (hdr) begin
            expMem[i][expCnt[i] % MEM] = 8'hA5;
            expCnt[i]++;
        end
        for (int k = 0; k < nb; k++) begin
            b = word[8*(nb-1-k) +: 8];
            expMem[i][expCnt[i] % MEM] = b;
            expCnt[i]++;
            x = x ^ b;
        end
        if (cs) begin
            expMem[i][expCnt[i] % MEM] = x;
            expCnt[i]++;
        end
    endtask

    task automatic syncModel();
        for (int i = 0; i < 3; i++) begin
            capPtr[i]   = capCnt[i];
            expPtr[i]   = expCnt[i];
            doneBase[i] = doneCnt[i];
        end
    endtask

    task automatic doReset();
        forceBusy = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        syncModel();
    endtask

    task automatic waitDrain(input int i);
        int guard;
        guard = 0;
        while (((capCnt[i] - capPtr[i]) < (expCnt[i] - expPtr[i]) || frameActive[i]) && guard < 20000) begin
            tick();
            guard++;
        end
        tick();
        checkOutput($sformatf("drain_timeout%0d", i), 32'(guard < 20000), 32'd1);
    endtask

    task automatic waitBytes(input int i, input int n);
        int guard;
        guard = 0;
        while ((capCnt[i] - capPtr[i]) < n && guard < 5000) begin
            tick();
            guard++;
        end
        checkOutput($sformatf("bytes_timeout%0d", i), 32'(guard < 5000), 32'd1);
    endtask

    task automatic compareStream(input int i, input string tag);
        int n;
        n = expCnt[i] - expPtr[i];
        checkOutput({tag, "_len"}, capCnt[i] - capPtr[i], n);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_byte%0d", tag, k), 32'(capMem[i][(capPtr[i] + k) % MEM]),
                        32'(expMem[i][(expPtr[i] + k) % MEM]));
        end
        capPtr[i] = capCnt[i];
        expPtr[i] = expCnt[i];
    endtask

    function automatic logic [255:0] randWord();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        logic [255:0] incWord;
        logic [255:0] w1, w2, w3, w4;
        int snap;

        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        inValid = '0;
        inData0 = '0;
        inData1 = '0;
        inData2 = '0;
        forceBusy = '0;
        issued = '0;
        for (int i = 0; i < 3; i++) begin
            busyCnt[i] = 0; capCnt[i] = 0; capPtr[i] = 0; expCnt[i] = 0; expPtr[i] = 0;
            doneCnt[i] = 0; doneBase[i] = 0; violations[i] = 0;
        end
        for (int k = 0; k < 32; k++) incWord[8*(31-k) +: 8] = 8'(k);

        repeat (3) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_in_ready%0d", i), 32'(inReady[i]), 32'd1);
            checkOutput($sformatf("rst_tx_valid%0d", i), 32'(txValid[i]), 32'd0);
            checkOutput($sformatf("rst_active%0d", i), 32'(frameActive[i]), 32'd0);
            checkOutput($sformatf("rst_done%0d", i), 32'(frameDone[i]), 32'd0);
            checkOutput($sformatf("rst_overflow%0d", i), 32'(overflow[i]), 32'd0);
            checkOutput($sformatf("rst_frames%0d", i), 32'(framesSent[i]), 32'd0);
        end

        $display("[TB] incrementing payload with header and checksum");
        doReset();
        applyStimulus(0, incWord);
        pushFrame(0, incWord, 32, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("lat_n1_tx_valid", 32'(txValid[0]), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("lat_n2_tx_valid", 32'(txValid[0]), 32'd1);
        checkOutput("lat_n2_tx_byte", 32'(txByte[0]), 32'hA5);
        waitDrain(0);
        compareStream(0, "inc");
        checkOutput("inc_done_pulses", doneCnt[0] - doneBase[0], 32'd1);
        checkOutput("inc_frames", 32'(framesSent[0]), 32'd1);
        checkOutput("inc_overflow", 32'(overflow[0]), 32'd0);

        $display("[TB] all-FF payload without header, 32 and 3 bytes");
        doReset();
        applyStimulus(1, {256{1'b1}});
        pushFrame(1, {256{1'b1}}, 32, 1'b0, 1'b1);
        applyStimulus(2, {256{1'b1}});
        pushFrame(2, {256{1'b1}}, 3, 1'b0, 1'b1);
        waitDrain(1);
        waitDrain(2);
        compareStream(1, "ff32");
        compareStream(2, "ff3");
        checkOutput("ff32_frames", 32'(framesSent[1]), 32'd1);
        checkOutput("ff3_frames", 32'(framesSent[2]), 32'd1);

        $display("[TB] two strobes five cycles apart");
        doReset();
        w1 = randWord();
        w2 = randWord();
        applyStimulus(0, w1);
        repeat (4) tick();
        applyStimulus(0, w2);
        pushFrame(0, w1, 32, 1'b1, 1'b1);
        pushFrame(0, w2, 32, 1'b1, 1'b1);
        waitDrain(0);
        compareStream(0, "b2b");
        checkOutput("b2b_overflow", 32'(overflow[0]), 32'd0);
        checkOutput("b2b_frames", 32'(framesSent[0]), 32'd2);
        checkOutput("b2b_done_pulses", doneCnt[0] - doneBase[0], 32'd2);

        $display("[TB] three strobes, third dropped");
        doReset();
        w1 = randWord();
        w2 = randWord();
        w3 = randWord();
        applyStimulus(0, w1);
        repeat (4) tick();
        applyStimulus(0, w2);
        repeat (4) tick();
        applyStimulus(0, w3);
        pushFrame(0, w1, 32, 1'b1, 1'b1);
        pushFrame(0, w2, 32, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("ovf_set", 32'(overflow[0]), 32'd1);
        waitDrain(0);
        compareStream(0, "ovf");
        checkOutput("ovf_sticky", 32'(overflow[0]), 32'd1);
        checkOutput("ovf_frames", 32'(framesSent[0]), 32'd2);

        $display("[TB] busy held at payload byte 5");
        doReset();
        applyStimulus(0, incWord);
        pushFrame(0, incWord, 32, 1'b1, 1'b1);
        waitBytes(0, 6);
        forceBusy[0] = 1'b1;
        snap = capCnt[0];
        repeat (100) tick();
        checkOutput("hold_no_issue", capCnt[0], snap);
        forceBusy[0] = 1'b0;
        @(negedge clk);
        checkOutput("hold_release_valid", 32'(txValid[0]), 32'd1);
        checkOutput("hold_release_byte", 32'(txByte[0]), 32'h05);
        waitDrain(0);
        compareStream(0, "hold");
        checkOutput("hold_frames", 32'(framesSent[0]), 32'd1);

        $display("[TB] reset in the middle of a payload");
        doReset();
        w1 = randWord();
        w2 = randWord();
        w3 = randWord();
        applyStimulus(0, w1);
        repeat (4) tick();
        applyStimulus(0, w2);
        repeat (4) tick();
        applyStimulus(0, w3);
        @(negedge clk);
        checkOutput("midrst_ovf_before", 32'(overflow[0]), 32'd1);
        waitBytes(0, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_tx_valid", 32'(txValid[0]), 32'd0);
        checkOutput("midrst_active", 32'(frameActive[0]), 32'd0);
        checkOutput("midrst_in_ready", 32'(inReady[0]), 32'd1);
        checkOutput("midrst_overflow", 32'(overflow[0]), 32'd0);
        checkOutput("midrst_frames", 32'(framesSent[0]), 32'd0);
        tick();
        syncModel();
        w4 = randWord();
        snap = capCnt[0];
        applyStimulus(0, w4);
        pushFrame(0, w4, 32, 1'b1, 1'b1);
        waitDrain(0);
        checkOutput("midrst_first_hdr", 32'(capMem[0][snap % MEM]), 32'hA5);
        compareStream(0, "midrst");
        checkOutput("midrst_frames_after", 32'(framesSent[0]), 32'd1);

        $display("[TB] randomized payloads");
        doReset();
        for (int f = 0; f < 4; f++) begin
            w1 = randWord();
            applyStimulus(0, w1);
            pushFrame(0, w1, 32, 1'b1, 1'b1);
            w2 = randWord();
            applyStimulus(2, w2);
            pushFrame(2, w2, 3, 1'b0, 1'b1);
            repeat (100) tick();
            w3 = randWord();
            applyStimulus(2, w3);
            pushFrame(2, w3, 3, 1'b0, 1'b1);
            repeat (450) tick();
        end
        waitDrain(0);
        waitDrain(2);
        compareStream(0, "rndA");
        compareStream(2, "rndC");
        checkOutput("rndA_frames", 32'(framesSent[0]), 32'd4);
        checkOutput("rndC_frames", 32'(framesSent[2]), 32'd8);
        checkOutput("rndA_overflow", 32'(overflow[0]), 32'd0);
        checkOutput("rndC_overflow", 32'(overflow[2]), 32'd0);

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("issue_while_busy%0d", i), violations[i], 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
